// File: rtl/id_stage_if.sv
// Decode-stage bus: fetch latch and writeback in, fetch control and ID/EX out.
// master drives instructions and writeback, slave is the decode stage.
interface id_stage_if #(
   parameter int W = 16
);
   logic [W-1:0] id_instr;
   logic [W-1:0] id_instr_addr;
   logic         id_valid;
   logic         wb_wr_en;
   logic [2:0]   wb_rd;
   logic [W-1:0] wb_data;
   logic         PC_WR_EN;
   logic         FE_LATCH_WR;
   logic         fe_flush;
   logic [1:0]   ctr_sig;
   logic [W-1:0] next_pc_in;
   logic         ex_valid;
   logic         ex_wr_en;
   logic [3:0]   ex_op;
   logic [2:0]   ex_rd;
   logic [W-1:0] ex_a;
   logic [W-1:0] ex_b;
   logic [W-1:0] ex_imm;
   logic [W-1:0] ex_instr_addr;
   logic         halted;

   modport master (
      output id_instr, id_instr_addr, id_valid,
      output wb_wr_en, wb_rd, wb_data,
      input  PC_WR_EN, FE_LATCH_WR, fe_flush,
      input  ctr_sig, next_pc_in,
      input  ex_valid, ex_wr_en, ex_op, ex_rd,
      input  ex_a, ex_b, ex_imm, ex_instr_addr,
      input  halted
   );

   modport slave (
      input  id_instr, id_instr_addr, id_valid,
      input  wb_wr_en, wb_rd, wb_data,
      output PC_WR_EN, FE_LATCH_WR, fe_flush,
      output ctr_sig, next_pc_in,
      output ex_valid, ex_wr_en, ex_op, ex_rd,
      output ex_a, ex_b, ex_imm, ex_instr_addr,
      output halted
   );
endinterface

// File: rtl/id_stage.sv
// Decode stage: register file, write scoreboard, hazard stall,
// branch/jump resolution and the ID/EX latch.
module id_stage #(
   parameter int NREG = 8,
   parameter int W    = 16
) (
   input logic       CLOCK_50,
   input logic       reset,
   id_stage_if.slave bus
);
   typedef enum logic {S_RUN, S_HALT} state_e;

   typedef struct packed {
      logic         valid;
      logic         wr_en;
      logic [3:0]   op;
      logic [2:0]   rd;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] imm;
      logic [W-1:0] addr;
   } id_ex_t;

   logic [W-1:0]    rf_q [NREG];
   logic [W-1:0]    rf_d [NREG];
   logic [NREG-1:0] busy_q, busy_d;
   logic [NREG-1:0] wb_clr, busy_eff;
   state_e          state_q, state_d;
   id_ex_t          ex_q, ex_d;
   logic            halted_q, halted_d;

   logic [3:0]   op;
   logic [2:0]   rd, src_a, src_b;
   logic [W-1:0] imm, a_val, b_val, target;
   logic         is_wr, use_a, use_b, b_is_rd;
   logic         is_br, is_jmp, is_halt;
   logic         running, hazard, stall, issue, taken;

   assign op    = bus.id_instr[15:12];
   assign rd    = bus.id_instr[11:9];
   assign src_a = bus.id_instr[8:6];
   assign src_b = b_is_rd ? rd : bus.id_instr[5:3];
   assign imm   = {{(W-6){bus.id_instr[5]}}, bus.id_instr[5:0]};

   always_comb begin
      is_wr   = 1'b0;
      use_a   = 1'b0;
      use_b   = 1'b0;
      b_is_rd = 1'b0;
      is_br   = 1'b0;
      is_jmp  = 1'b0;
      is_halt = 1'b0;
      unique case (op)
         4'h0, 4'h1, 4'h2, 4'h3: begin
            is_wr = 1'b1;
            use_a = 1'b1;
            use_b = 1'b1;
         end
         4'h4, 4'h5: begin
            is_wr = 1'b1;
            use_a = 1'b1;
         end
         4'h6: begin
            use_a   = 1'b1;
            use_b   = 1'b1;
            b_is_rd = 1'b1;
         end
         4'h7, 4'h8: begin
            use_a   = 1'b1;
            use_b   = 1'b1;
            b_is_rd = 1'b1;
            is_br   = 1'b1;
         end
         4'h9:    is_jmp  = 1'b1;
         4'hF:    is_halt = 1'b1;
         default: ;
      endcase
   end

   // Reads see a same-cycle writeback; r0 never does.
   assign a_val = (src_a == 3'd0) ? '0 :
      (bus.wb_wr_en && bus.wb_rd == src_a) ?
      bus.wb_data : rf_q[src_a];
   assign b_val = (src_b == 3'd0) ? '0 :
      (bus.wb_wr_en && bus.wb_rd == src_b) ?
      bus.wb_data : rf_q[src_b];

   assign wb_clr   = bus.wb_wr_en ?
      (NREG'(1) << bus.wb_rd) : '0;
   assign busy_eff = busy_q & ~wb_clr;

   assign running = (state_q == S_RUN);
   assign hazard  = (use_a && busy_eff[src_a]) ||
                    (use_b && busy_eff[src_b]) ||
                    (is_wr && busy_eff[rd]);
   assign stall   = bus.id_valid && running && hazard;
   assign issue   = bus.id_valid && running && !hazard;
   assign taken   = issue && (is_jmp ||
                    (op == 4'h7 && a_val == b_val) ||
                    (op == 4'h8 && a_val != b_val));
   assign target  = is_jmp ?
      {bus.id_instr_addr[W-1:12], bus.id_instr[11:0]} :
      bus.id_instr_addr + W'(1) + imm;

   always_comb begin
      bus.PC_WR_EN    = 1'b1;
      bus.FE_LATCH_WR = 1'b1;
      bus.fe_flush    = 1'b0;
      bus.ctr_sig     = 2'b00;
      bus.next_pc_in  = '0;
      if (!reset) begin
         unique case (1'b1)
            stall || !running: begin
               bus.PC_WR_EN    = 1'b0;
               bus.FE_LATCH_WR = 1'b0;
               bus.ctr_sig     = 2'b10;
            end
            taken: begin
               bus.fe_flush   = 1'b1;
               bus.ctr_sig    = 2'b01;
               bus.next_pc_in = target;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      ex_d = '0;
      if (issue && !is_br && !is_jmp) begin
         ex_d.valid = 1'b1;
         ex_d.wr_en = is_wr && (rd != 3'd0);
         ex_d.op    = op;
         ex_d.rd    = rd;
         ex_d.a     = use_a ? a_val : '0;
         ex_d.b     = use_b ? b_val : '0;
         ex_d.imm   = imm;
         ex_d.addr  = bus.id_instr_addr;
      end
   end

   // A set in the same cycle as a writeback clear wins.
   always_comb begin
      busy_d = busy_q & ~wb_clr;
      if (issue && is_wr && rd != 3'd0)
         busy_d[rd] = 1'b1;
      busy_d[0] = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      if (issue && is_halt)
         state_d = S_HALT;
      halted_d = (state_d == S_HALT);
   end

   always_comb begin
      rf_d = rf_q;
      if (bus.wb_wr_en && bus.wb_rd != 3'd0)
         rf_d[bus.wb_rd] = bus.wb_data;
   end

   always_ff @(posedge CLOCK_50)
      rf_q <= rf_d;

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q  <= S_RUN;
         busy_q   <= '0;
         ex_q     <= '0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         busy_q   <= busy_d;
         ex_q     <= ex_d;
         halted_q <= halted_d;
      end
   end

   assign bus.ex_valid      = ex_q.valid;
   assign bus.ex_wr_en      = ex_q.wr_en;
   assign bus.ex_op         = ex_q.op;
   assign bus.ex_rd         = ex_q.rd;
   assign bus.ex_a          = ex_q.a;
   assign bus.ex_b          = ex_q.b;
   assign bus.ex_imm        = ex_q.imm;
   assign bus.ex_instr_addr = ex_q.addr;
   assign bus.halted        = halted_q;
endmodule

// File: tb/tb_id_stage.sv
// Vector table plus expected-ID/EX queue for the decode stage;
// hand sequences cover HALT and reset.
module tb_id_stage;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   id_stage_if bus ();

   id_stage dut (
      .CLOCK_50(clk),
      .reset   (reset),
      .bus     (bus)
   );

   typedef struct packed {
      logic        valid;
      logic        wr;
      logic [3:0]  op;
      logic [2:0]  rd;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] imm;
      logic [15:0] addr;
   } ex_t;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] addr;
      logic        valid;
      logic        wen;
      logic [2:0]  wrd;
      logic [15:0] wdat;
      logic        pc_we;
      logic        fe_we;
      logic        flush;
      logic [1:0]  ctr;
      logic [15:0] npc;
      logic        halted;
      ex_t         ex;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;
   vec_t tv[$];
   ex_t  exq[$];

   function automatic logic [15:0] enc_r(
      input logic [3:0] op, input logic [2:0] rd,
      input logic [2:0] rs1, input logic [2:0] rs2);
      return {op, rd, rs1, rs2, 3'b000};
   endfunction

   function automatic logic [15:0] enc_i(
      input logic [3:0] op, input logic [2:0] rd,
      input logic [2:0] rs1, input int imm);
      logic [5:0] i6;
      i6 = imm[5:0];
      return {op, rd, rs1, i6};
   endfunction

   function automatic vec_t mk(
      input logic [15:0] instr, input logic [15:0] addr,
      input logic valid, input logic wen,
      input logic [2:0] wrd, input logic [15:0] wdat);
      vec_t v;
      v.instr  = instr;
      v.addr   = addr;
      v.valid  = valid;
      v.wen    = wen;
      v.wrd    = wrd;
      v.wdat   = wdat;
      v.pc_we  = 1'b1;
      v.fe_we  = 1'b1;
      v.flush  = 1'b0;
      v.ctr    = 2'b00;
      v.npc    = 16'h0000;
      v.halted = 1'b0;
      v.ex     = '0;
      return v;
   endfunction

   function automatic vec_t hold(input vec_t v);
      v.pc_we = 1'b0;
      v.fe_we = 1'b0;
      v.ctr   = 2'b10;
      return v;
   endfunction

   function automatic vec_t take(input vec_t v, input logic [15:0] t);
      v.ctr   = 2'b01;
      v.npc   = t;
      v.flush = 1'b1;
      return v;
   endfunction

   function automatic vec_t iss(input vec_t v, input logic wr,
      input logic [15:0] a, input logic [15:0] b);
      v.ex.valid = 1'b1;
      v.ex.wr    = wr;
      v.ex.op    = v.instr[15:12];
      v.ex.rd    = v.instr[11:9];
      v.ex.a     = a;
      v.ex.b     = b;
      v.ex.imm   = {{10{v.instr[5]}}, v.instr[5:0]};
      v.ex.addr  = v.addr;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act,
      input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      ex_t e;
      bus.id_instr      = v.instr;
      bus.id_instr_addr = v.addr;
      bus.id_valid      = v.valid;
      bus.wb_wr_en      = v.wen;
      bus.wb_rd         = v.wrd;
      bus.wb_data       = v.wdat;
      exq.push_back(v.ex);
      @(negedge clk);
      chk({tag, ".pc_we"}, 16'(bus.PC_WR_EN), 16'(v.pc_we));
      chk({tag, ".fe_we"}, 16'(bus.FE_LATCH_WR), 16'(v.fe_we));
      chk({tag, ".flush"}, 16'(bus.fe_flush), 16'(v.flush));
      chk({tag, ".ctr"}, 16'(bus.ctr_sig), 16'(v.ctr));
      chk({tag, ".npc"}, bus.next_pc_in, v.npc);
      chk({tag, ".halted"}, 16'(bus.halted), 16'(v.halted));
      @(posedge clk);
      #1;
      e = exq.pop_front();
      chk({tag, ".ex_valid"}, 16'(bus.ex_valid), 16'(e.valid));
      chk({tag, ".ex_wr"}, 16'(bus.ex_wr_en), 16'(e.wr));
      chk({tag, ".ex_op"}, 16'(bus.ex_op), 16'(e.op));
      chk({tag, ".ex_rd"}, 16'(bus.ex_rd), 16'(e.rd));
      chk({tag, ".ex_a"}, bus.ex_a, e.a);
      chk({tag, ".ex_b"}, bus.ex_b, e.b);
      chk({tag, ".ex_imm"}, bus.ex_imm, e.imm);
      chk({tag, ".ex_addr"}, bus.ex_instr_addr, e.addr);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".ex_valid"}, 16'(bus.ex_valid), 16'h0);
      chk({tag, ".ex_wr"}, 16'(bus.ex_wr_en), 16'h0);
      chk({tag, ".ex_op"}, 16'(bus.ex_op), 16'h0);
      chk({tag, ".ex_rd"}, 16'(bus.ex_rd), 16'h0);
      chk({tag, ".ex_a"}, bus.ex_a, 16'h0);
      chk({tag, ".ex_b"}, bus.ex_b, 16'h0);
      chk({tag, ".ex_imm"}, bus.ex_imm, 16'h0);
      chk({tag, ".ex_addr"}, bus.ex_instr_addr, 16'h0);
      chk({tag, ".halted"}, 16'(bus.halted), 16'h0);
      chk({tag, ".flush"}, 16'(bus.fe_flush), 16'h0);
      chk({tag, ".ctr"}, 16'(bus.ctr_sig), 16'h0);
      chk({tag, ".npc"}, bus.next_pc_in, 16'h0);
      chk({tag, ".pc_we"}, 16'(bus.PC_WR_EN), 16'h1);
      chk({tag, ".fe_we"}, 16'(bus.FE_LATCH_WR), 16'h1);
   endtask

   task automatic do_reset(input string tag);
      reset             = 1'b1;
      bus.id_valid      = 1'b1;
      bus.id_instr      = enc_i(4'h7, 3'd0, 3'd0, -3);
      bus.id_instr_addr = 16'h0010;
      bus.wb_wr_en      = 1'b0;
      bus.wb_rd         = 3'd0;
      bus.wb_data       = 16'h0000;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk_reset(tag);
      reset        = 1'b0;
      bus.id_valid = 1'b0;
   endtask

   initial begin
      vec_t v;
      do_reset("rst0");

      tv.push_back(mk(16'h0, 16'h0, 0, 1, 3'd2, 16'd5));
      tv.push_back(mk(16'h0, 16'h0, 0, 1, 3'd3, 16'd7));
      tv.push_back(mk(16'h0, 16'h0, 0, 1, 3'd5, 16'd9));
      tv.push_back(mk(16'h0, 16'h0, 0, 1, 3'd6, 16'd9));
      tv.push_back(iss(mk(enc_r(4'h0, 3'd1, 3'd2, 3'd3),
         16'h0100, 1, 0, 3'd0, 16'h0), 1, 16'd5, 16'd7));
      tv.push_back(hold(mk(enc_r(4'h0, 3'd4, 3'd1, 3'd1),
         16'h0101, 1, 0, 3'd0, 16'h0)));
      tv.push_back(iss(mk(enc_r(4'h0, 3'd4, 3'd1, 3'd1),
         16'h0101, 1, 1, 3'd1, 16'h000C), 1, 16'h000C, 16'h000C));
      tv.push_back(iss(mk(enc_i(4'h4, 3'd1, 3'd2, 3),
         16'h0102, 1, 0, 3'd0, 16'h0), 1, 16'd5, 16'd0));
      tv.push_back(hold(mk(enc_r(4'h0, 3'd5, 3'd1, 3'd1),
         16'h0103, 1, 0, 3'd0, 16'h0)));
      tv.push_back(hold(mk(enc_r(4'h0, 3'd5, 3'd1, 3'd1),
         16'h0103, 1, 0, 3'd0, 16'h0)));
      tv.push_back(iss(mk(enc_r(4'h0, 3'd5, 3'd1, 3'd1),
         16'h0103, 1, 1, 3'd1, 16'd8), 1, 16'd8, 16'd8));
      tv.push_back(mk(16'h0, 16'h0, 0, 1, 3'd4, 16'h1234));
      tv.push_back(mk(16'h0, 16'h0, 0, 1, 3'd5, 16'd9));
      tv.push_back(take(mk(enc_i(4'h7, 3'd0, 3'd0, -3),
         16'h0010, 1, 0, 3'd0, 16'h0), 16'h000E));
      tv.push_back(take(mk(16'h9ABC, 16'h5123, 1, 0, 3'd0,
         16'h0), 16'h5ABC));
      tv.push_back(mk(enc_i(4'h8, 3'd5, 3'd6, 5),
         16'h0200, 1, 0, 3'd0, 16'h0));
      tv.push_back(take(mk(enc_i(4'h8, 3'd5, 3'd2, -1),
         16'h0200, 1, 0, 3'd0, 16'h0), 16'h0200));
      tv.push_back(take(mk(enc_i(4'h7, 3'd0, 3'd0, 2),
         16'hFFFF, 1, 0, 3'd0, 16'h0), 16'h0002));
      tv.push_back(iss(mk(enc_i(4'h4, 3'd2, 3'd0, 1),
         16'h0300, 1, 0, 3'd0, 16'h0), 1, 16'd0, 16'd0));
      tv.push_back(iss(mk(enc_i(4'h4, 3'd2, 3'd0, 2),
         16'h0301, 1, 1, 3'd2, 16'h0055), 1, 16'd0, 16'd0));
      tv.push_back(hold(mk(enc_r(4'h0, 3'd7, 3'd2, 3'd0),
         16'h0302, 1, 0, 3'd0, 16'h0)));
      tv.push_back(mk(16'h0, 16'h0, 0, 1, 3'd2, 16'h0066));
      tv.push_back(iss(mk(enc_r(4'h0, 3'd7, 3'd2, 3'd0),
         16'h0303, 1, 0, 3'd0, 16'h0), 1, 16'h0066, 16'd0));
      tv.push_back(iss(mk(enc_r(4'h0, 3'd0, 3'd2, 3'd3),
         16'h0304, 1, 0, 3'd0, 16'h0), 0, 16'h0066, 16'd7));
      tv.push_back(iss(mk(enc_r(4'h0, 3'd1, 3'd0, 3'd0),
         16'h0305, 1, 1, 3'd0, 16'hFFFF), 1, 16'd0, 16'd0));

      foreach (tv[i])
         run_vec(tv[i], $sformatf("v%0d", i));

      run_vec(iss(mk(16'hF000, 16'h0400, 1, 0, 3'd0, 16'h0),
         0, 16'd0, 16'd0), "halt");
      for (int k = 0; k < 12; k++) begin
         v = hold(mk(enc_r(4'h0, 3'd3, 3'd2, 3'd2), 16'h0401,
            1, k == 3, 3'd6, 16'h4242));
         v.halted = 1'b1;
         run_vec(v, $sformatf("h%0d", k));
      end

      do_reset("rst1");
      run_vec(iss(mk(enc_r(4'h0, 3'd1, 3'd6, 3'd0),
         16'h0500, 1, 0, 3'd0, 16'h0), 1, 16'h4242, 16'd0),
         "post");
      run_vec(mk(16'h0, 16'h0, 0, 0, 3'd0, 16'h0), "idle");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
